// File: rtl/ssio_sdr_in_align.sv
// ssio_sdr_in_align
//   Multi-lane deskew and alignment stage placed after per-lane SDR capture.
//   A training word is searched on the raw lanes. The arrival offsets are
//   measured and turned into per-lane tap delays so that every lane lines up.
//   Lock is then confirmed on the deskewed data before "aligned" is raised.
//
// Ports
//   clk           single clock
//   rst           synchronous reset, active high
//   input_d       captured lane data, lane i at [i*LANE_WIDTH +: LANE_WIDTH]
//   input_valid   qualifies input_d; every pipeline and the FSM hold while low
//   align_req     one-cycle pulse that restarts alignment from SEARCH
//   output_q      deskewed data (registered)
//   output_valid  input_valid delayed by one clock
//   aligned       high while locked
//   align_error   sticky skew-overflow flag, cleared by align_req or rst
//   lane_delay    tap delay currently applied to each lane, DELAY_W bits per lane

// ---------------------------------------------------------------------------
// Per-lane delay line. Tap 0 is the live input and tap k (k >= 1) is the word
// from k valid cycles ago. The selected tap is registered into o_q on every
// valid cycle. o_tap is the unregistered tap, used for the lock check.
// ---------------------------------------------------------------------------
module ssio_sdr_in_align_lane #(
    parameter int LANE_WIDTH = 8,
    parameter int MAX_SKEW   = 7,
    parameter int DELAY_W    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANE_WIDTH-1:0] i_d,
    input  logic                  i_valid,
    input  logic [DELAY_W-1:0]    i_delay,
    output logic [LANE_WIDTH-1:0] o_tap,
    output logic [LANE_WIDTH-1:0] o_q
);

    // Together with the live input, this gives MAX_SKEW+1 taps.
    logic [LANE_WIDTH-1:0] r_sh [0:MAX_SKEW-1];
    logic [LANE_WIDTH-1:0] r_q;

    always_comb begin
        o_tap = i_d;
        for (int k = 1; k <= MAX_SKEW; k++) begin
            if (i_delay == DELAY_W'(k)) begin
                o_tap = r_sh[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MAX_SKEW; k++) begin
                r_sh[k] <= '0;
            end
            r_q <= '0;
        end else if (i_valid) begin
            r_sh[0] <= i_d;
            for (int k = 1; k < MAX_SKEW; k++) begin
                r_sh[k] <= r_sh[k-1];
            end
            r_q <= o_tap;
        end
    end

    assign o_q = r_q;

endmodule

// ---------------------------------------------------------------------------
// Top level: lane array plus the search / measure / check / lock FSM.
// ---------------------------------------------------------------------------
module ssio_sdr_in_align #(
    parameter int                    LANES         = 4,
    parameter int                    LANE_WIDTH    = 8,
    parameter int                    MAX_SKEW      = 7,
    parameter int                    DELAY_W       = 3,
    parameter logic [LANE_WIDTH-1:0] TRAIN_PATTERN = 8'hBC,
    parameter int                    LOCK_COUNT    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES*LANE_WIDTH-1:0] input_d,
    input  logic                        input_valid,
    input  logic                        align_req,
    output logic [LANES*LANE_WIDTH-1:0] output_q,
    output logic                        output_valid,
    output logic                        aligned,
    output logic                        align_error,
    output logic [LANES*DELAY_W-1:0]    lane_delay
);

    // The skew counter needs one extra bit so that it can show MAX_SKEW+1.
    localparam int CNT_W = DELAY_W + 1;
    localparam int MC_W  = $clog2(LOCK_COUNT + 1);

    typedef enum logic [2:0] {
        S_SEARCH  = 3'd0,
        S_MEASURE = 3'd1,
        S_CHECK   = 3'd2,
        S_LOCKED  = 3'd3,
        S_FAIL    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [LANES-1:0][LANE_WIDTH-1:0] w_raw;
    logic [LANES-1:0][LANE_WIDTH-1:0] w_tap;
    logic [LANES-1:0][LANE_WIDTH-1:0] w_q;
    logic [LANES-1:0]                 w_raw_hit;
    logic [LANES-1:0]                 w_tap_hit;
    logic [LANES-1:0]                 w_hit_now;

    logic [LANES-1:0][DELAY_W-1:0]    r_delay;
    logic [LANES-1:0][DELAY_W-1:0]    r_hit_time;
    logic [LANES-1:0]                 r_hit;
    logic [DELAY_W-1:0]               r_skew_cnt;
    logic [MC_W-1:0]                  r_match_cnt;
    logic                             r_err;
    logic                             r_out_valid;

    logic [CNT_W-1:0]                 w_cnt;
    logic                             w_ovf;
    logic                             w_all_hit;
    logic [MC_W-1:0]                  w_match_nxt;
    logic                             w_lock;

    assign w_raw = input_d;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            ssio_sdr_in_align_lane #(
                .LANE_WIDTH (LANE_WIDTH),
                .MAX_SKEW   (MAX_SKEW),
                .DELAY_W    (DELAY_W)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .i_d     (w_raw[gi]),
                .i_valid (input_valid),
                .i_delay (r_delay[gi]),
                .o_tap   (w_tap[gi]),
                .o_q     (w_q[gi])
            );
            assign w_raw_hit[gi] = (w_raw[gi] == TRAIN_PATTERN);
            assign w_tap_hit[gi] = (w_tap[gi] == TRAIN_PATTERN);
        end
    endgenerate

    // In MEASURE, a lane counts as hit when it has already hit or hits now.
    // A lane that hits on the same cycle as the last un-hit lane records the
    // current count, so it gets zero delay.
    assign w_cnt       = {1'b0, r_skew_cnt} + CNT_W'(1);
    assign w_ovf       = (w_cnt > CNT_W'(MAX_SKEW));
    assign w_hit_now   = r_hit | w_raw_hit;
    assign w_all_hit   = &w_hit_now;
    assign w_match_nxt = r_match_cnt + MC_W'(1);
    assign w_lock      = (w_match_nxt == MC_W'(LOCK_COUNT));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_SEARCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic. Only valid cycles advance the FSM. align_req
    // overrides any transition made in the same cycle.
    always_comb begin
        w_next = r_state;
        if (align_req) begin
            w_next = S_SEARCH;
        end else if (input_valid) begin
            case (r_state)
                S_SEARCH: begin
                    if (|w_raw_hit) begin
                        w_next = (&w_raw_hit) ? S_CHECK : S_MEASURE;
                    end
                end
                S_MEASURE: begin
                    if (w_ovf) begin
                        w_next = S_FAIL;
                    end else if (w_all_hit) begin
                        w_next = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (&w_tap_hit) begin
                        if (w_lock) begin
                            w_next = S_LOCKED;
                        end
                    end else if (|w_tap_hit) begin
                        w_next = S_SEARCH;
                    end
                end
                S_LOCKED: w_next = S_LOCKED;
                S_FAIL:   w_next = S_FAIL;
                default:  w_next = S_SEARCH;
            endcase
        end
    end

    // Output logic
    always_comb begin
        aligned = (r_state == S_LOCKED);
    end

    // Measurement, delay and lock-count datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_delay     <= '0;
            r_hit_time  <= '0;
            r_hit       <= '0;
            r_skew_cnt  <= '0;
            r_match_cnt <= '0;
            r_err       <= 1'b0;
        end else if (align_req) begin
            r_delay     <= '0;
            r_hit       <= '0;
            r_skew_cnt  <= '0;
            r_match_cnt <= '0;
            r_err       <= 1'b0;
        end else if (input_valid) begin
            case (r_state)
                S_SEARCH: begin
                    r_delay     <= '0;
                    r_match_cnt <= '0;
                    r_skew_cnt  <= '0;
                    r_hit       <= w_raw_hit;
                    r_hit_time  <= '0;
                end
                S_MEASURE: begin
                    if (w_ovf) begin
                        r_err <= 1'b1;
                    end else begin
                        r_skew_cnt <= w_cnt[DELAY_W-1:0];
                        r_hit      <= w_hit_now;
                        for (int i = 0; i < LANES; i++) begin
                            if (!r_hit[i] && w_raw_hit[i]) begin
                                r_hit_time[i] <= w_cnt[DELAY_W-1:0];
                            end
                            if (w_all_hit) begin
                                r_delay[i] <= w_cnt[DELAY_W-1:0] -
                                    (r_hit[i] ? r_hit_time[i] : w_cnt[DELAY_W-1:0]);
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (&w_tap_hit) begin
                        r_match_cnt <= w_match_nxt;
                    end else if (|w_tap_hit) begin
                        r_match_cnt <= '0;
                        r_delay     <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= input_valid;
        end
    end

    assign output_q     = w_q;
    assign output_valid = r_out_valid;
    assign align_error  = r_err;
    assign lane_delay   = r_delay;

endmodule

// File: doc/ssio_sdr_in_align.md
Name: ssio_sdr_in_align

Overview:
Multi-lane deskew and alignment stage placed after the per-lane source-synchronous SDR capture.
- Input: LANES lanes of LANE_WIDTH-bit words, already captured into a single clock domain.
- Operation: a training-pattern search measures inter-lane skew of up to MAX_SKEW valid cycles, applies a per-lane delay so all lanes line up, then verifies lock before declaring the bus aligned.
- Downstream MAC/PCS logic consumes output_q only while aligned is high.

Parameters:
- LANES, 4, number of independent data lanes.
- LANE_WIDTH, 8, bits per lane per word.
- MAX_SKEW, 7, maximum correctable skew in valid cycles (≥1).
- DELAY_W, 3, width of the per-lane delay field; must satisfy 2^DELAY_W > MAX_SKEW.
- TRAIN_PATTERN, 8'hBC, LANE_WIDTH-bit training word.
- LOCK_COUNT, 4, number of consecutive aligned pattern events required for lock (≥1).

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- input_d  in  LANES*LANE_WIDTH  captured lane data; lane i occupies bits [i*LANE_WIDTH +: LANE_WIDTH].
- input_valid  in  1  qualifies input_d; when low, all pipelines hold.
- align_req  in  1  single-cycle pulse that restarts alignment.
- output_q  out  LANES*LANE_WIDTH  deskewed data.
- output_valid  out  1  qualifies output_q.
- aligned  out  1  high in LOCKED state.
- align_error  out  1  sticky; set on skew overflow, cleared by align_req or rst.
- lane_delay  out  LANES*DELAY_W  currently applied delay per lane.

Behaviour:
Reset values:
- rst high for one cycle: FSM goes to SEARCH.
- output_q=0, output_valid=0, aligned=0, align_error=0, lane_delay=0.
- All delay lines are cleared to 0.

Delay line:
- Each lane has a shift register of depth MAX_SKEW+1. It shifts only when input_valid=1.
- Tap k is the word from k valid cycles ago. The lane uses tap lane_delay[i].
- output_q is registered: tap value on the cycle after the input_valid cycle.
- output_valid = input_valid delayed by 1 cycle.
- Latency: 1 clk + lane_delay[i] valid cycles.

FSM states: SEARCH, MEASURE, CHECK, LOCKED, FAIL. All transitions evaluate only on input_valid=1 cycles, except align_req and rst.

SEARCH:
- lane_delay is held at 0.
- On the first valid cycle where any lane's raw input equals TRAIN_PATTERN:
  - record hit_time=0 for every lane that matches on that cycle;
  - set skew_cnt=0;
  - if all lanes matched, go directly to CHECK with all delays 0;
  - otherwise go to MEASURE.

MEASURE:
- skew_cnt increments each valid cycle.
- A lane that has not yet hit and matches the pattern records hit_time=skew_cnt. Later matches on an already-hit lane are ignored.
- When all lanes have hit: lane_delay[i] = skew_cnt − hit_time[i], then go to CHECK. The new delays take effect on the next cycle.
- If skew_cnt would exceed MAX_SKEW with lanes still un-hit: set align_error=1 and go to FAIL.

CHECK:
- Operates on the deskewed tap data. match_cnt starts at 0.
- All lanes equal TRAIN_PATTERN: match_cnt increments. When it reaches LOCK_COUNT, go to LOCKED.
- Some but not all lanes equal TRAIN_PATTERN: clear match_cnt and lane_delay, go to SEARCH.
- No lane equals TRAIN_PATTERN: no change.

LOCKED:
- aligned=1.
- Partial matches are ignored, since payload may contain the pattern.
- Stays here until align_req or rst.

FAIL:
- Holds until align_req.

align_req (any state):
- Next cycle: SEARCH, aligned=0, align_error=0, lane_delay=0, match_cnt=0.
- Delay-line contents are retained.
- align_req takes priority over any same-cycle FSM transition.
- rst takes priority over align_req.

Boundary rules:
- Skew of exactly MAX_SKEW is accepted. Skew of MAX_SKEW+1 sets align_error.
- input_valid low during MEASURE: skew_cnt is frozen.
- A lane matching on the same cycle as the final un-hit lane records the current skew_cnt.

Test Plan:
- Zero skew: 4 lanes carry 0xBC simultaneously every 16 valid cycles → lane_delay all 0; aligned rises after the 4th aligned pattern event; output_q equals input_d delayed 1 clk.
- Skew {0,2,5,1} cycles (lane 0 earliest), pattern every 16 cycles → lane_delay={5,3,0,4}; aligned=1; payload words emerge on all lanes in the same cycle.
- Skew 8 on lane 3 with MAX_SKEW=7 → align_error=1, FSM in FAIL, aligned=0. A following align_req clears align_error, and the search restarts.
- In CHECK, inject a partial match (lanes 0 and 1 only) after 2 good events → match_cnt resets, lane_delay=0, re-search succeeds, aligned rises later.
- Skew 3 on lane 2 with input_valid toggling 50% → the same lane_delay values as with continuous valid; output_valid follows input_valid by 1 clk.
- In LOCKED, payload containing 0xBC on a single lane → aligned stays 1. Then align_req plus rst in the same cycle → reset values apply.
